// File: rtl/rx_pkg.sv
// Framing constants and state encoding for the 8N1 serial receiver.
// Tx and rx both import this package so they agree on the framing.
package rx_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 32;
    localparam int unsigned DATA_BITS_DEF    = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous inputs.
// Both flops reset to 1, which is the idle level of a serial line.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rx.sv
// 8N1 serial receiver: samples each bit at its centre and presents the byte
// with a one-cycle strobe, or a one-cycle framing-error strobe on a bad stop bit.
module rx
    import rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 DataIn,
    output logic [DATA_BITS-1:0] DataOut,
    output logic                 DataOutEn,
    output logic                 FrameErr,
    output logic                 Busy
);

    localparam int unsigned       CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);

    logic                 s;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 en_q, en_d;
    logic                 err_q, err_d;
    logic                 busy_q;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (DataIn),
        .q     (s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            en_q    <= en_d;
            err_q   <= err_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Sample counter free-runs and wraps at CLKS_PER_BIT, so every bit
    // after the start check is sampled when it reads all ones.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        en_d    = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    shift_d = {s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == DATA_LAST) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    if (s) begin
                        data_d  = shift_q;
                        en_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign DataOut   = data_q;
    assign DataOutEn = en_q;
    assign FrameErr  = err_q;
    assign Busy      = busy_q;

endmodule

// File: doc/rx.md
Name: rx

Overview:
- Serial receiver for the 8N1 byte-serial link driven by the team's Tx block.
- Deserialises one idle-high line with timing of 32 clocks per bit: start bit (0), 8 data bits LSB first, stop bit (1).
- Presents each received byte on a parallel bus with a one-cycle strobe, plus a framing-error flag.
- Sits at the far end of the link, on the same clock domain family as Tx; the serial input is treated as asynchronous.

Parameters:
CLKS_PER_BIT, 32, clocks per serial bit; must match Tx; power of two, >= 4
DATA_BITS, 8, data bits per frame

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
DataIn  input  1  serial line, idle high, asynchronous to clk
DataOut  output  DATA_BITS  last correctly framed byte
DataOutEn  output  1  one-cycle strobe: DataOut updated this cycle
FrameErr  output  1  one-cycle strobe: stop bit sampled 0
Busy  output  1  high while a frame is in progress (any state other than IDLE)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset==0 clears all state immediately, independent of clk).
- Reset values:
  - DataOut=0, DataOutEn=0, FrameErr=0, Busy=0.
  - Internal shift register 0; bit counter 0; sample counter 0.
  - Synchroniser flops 1 (idle level); state IDLE.
- Input sync: DataIn passes through 2 flops. All logic below uses the synchronised signal s. Cycle 0 is the first rising edge at which s==0 while in IDLE.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - Wait for s==0. On detection, enter START with sample counter cleared.
- START:
  - Count to CLKS_PER_BIT/2-1 (15 for default). Sample s at cycle 15 (mid start bit).
  - s==1 means glitch: return to IDLE, no strobe.
  - s==0 means valid start: enter DATA with sample counter cleared.
- DATA:
  - Sample s every CLKS_PER_BIT clocks. Data bit i is sampled at cycle 15+32*(i+1), i=0..7.
  - Each sample is shifted into bit DATA_BITS-1; the register shifts right, so the first-received bit ends in bit 0 (LSB first).
  - After bit DATA_BITS-1, enter STOP.
- STOP:
  - Sample s at cycle 15+32*9=303.
  - s==1: DataOut<=shift register and DataOutEn=1 at cycle 304 for exactly one cycle; return to IDLE immediately (half a bit early) so back-to-back frames are caught.
  - s==0: FrameErr=1 for one cycle at cycle 304; DataOut holds its previous value; enter WAIT_HIGH.
- WAIT_HIGH:
  - Stay until s==1, then go to IDLE.
  - A line held low (break) therefore produces exactly one FrameErr and no re-trigger.
- Outputs:
  - DataOutEn and FrameErr are never high in the same cycle and are zero in every other cycle.
  - DataOut changes only together with DataOutEn.
- Counters:
  - Sample counter is log2(CLKS_PER_BIT) bits wide and wraps naturally. Bit counter is 4 bits.
  - No arithmetic overflow is visible at the outputs.
- Reset mid-frame: the frame is abandoned, all outputs go to reset values, and no strobe is emitted. After release the block waits in IDLE; a line that is still low at release starts a new frame (tolerated, same as a glitch check).
- Minimum idle between frames: zero extra clocks beyond the stop bit's second half.

Decomposition:
- Shared package rx_pkg holds:
  - State encoding constants (IDLE=0, START=1, DATA=2, STOP=3, WAIT_HIGH=4; 3 bits).
  - Default CLKS_PER_BIT=32 and DATA_BITS=8, so Tx and rx share framing constants.
- One natural sub-module: sync_2ff, the 1-bit two-flop synchroniser, reset to 1 by active-low async reset. Reusable by other blocks.

Test Plan:
- Loopback: Tx.DataOut->rx.DataIn, same clk; pulse Tx DataInEn with DataIn=0xA5 -> exactly one DataOutEn, DataOut=0xA5, FrameErr never high, Busy falls after strobe.
- Back-to-back: Tx sends 0x00 then 0xFF with no gap -> two DataOutEn pulses, DataOut=0x00 then 0xFF, pulse spacing 320 clocks.
- Glitch: drive DataIn low for 10 clocks then high -> no strobe; Busy returns low; DataOut unchanged.
- Framing error: hand-built frame 0x3C with stop bit 0 -> FrameErr one cycle at cycle 304; DataOut keeps prior value; no DataOutEn.
- Break: hold DataIn low for 2000 clocks -> exactly one FrameErr; no further activity until the line goes high; then a valid 0x5A frame is received correctly.
- Reset mid-frame: assert reset low during data bit 4 of a 0x81 frame, release, send 0x42 -> no strobe for the aborted frame; all outputs 0 during reset; next DataOut=0x42.
